fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch front-end of the ARMv4 core. Owns the PC, issues word reads to instruction memory
//  over a req/gnt + rvalid interface, buffers in-order responses in a small FIFO and hands
//  {inst, pc} to the IF/ID pipeline register through a valid/ready handshake.
//  Execute-stage branch redirects flush the stage; in-flight stale responses are discarded.
// PARAMETERS
//  XLEN        32  address/data width
//  RESET_PC    0   PC loaded on reset (word aligned)
//  FIFO_DEPTH  2   instruction buffer entries; also the cap on outstanding + buffered fetches
// PORTS
//  clk          in   1     clock, all state updates on posedge
//  rst          in   1     asynchronous, active-high reset
//  imem_req     out  1     read request valid
//  imem_addr    out  XLEN  read address, bits [1:0] always 0
//  imem_gnt     in   1     request accepted this cycle (req && gnt = accept)
//  imem_rvalid  in   1     read data valid; one per accepted request, in order, latency >= 1
//  imem_rdata   in   XLEN  read data
//  br_taken     in   1     redirect pulse from execute
//  br_target    in   XLEN  redirect address; bits [1:0] ignored (forced 0)
//  inst_valid   out  1     instruction available to decode
//  dec_ready    in   1     decode accepts (pop = inst_valid && dec_ready)
//  inst         out  XLEN  instruction word
//  inst_pc      out  XLEN  address of inst
//  inst_pc8     out  XLEN  inst_pc + 8 (ARM PC read value), modulo 2^XLEN
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, discard=0;
//   imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_pc8=RESET_PC+8.
//  FSM states: IDLE -> FETCH (unconditional, 1 cycle after reset release);
//   FETCH -> DRAIN on br_taken when next discard > 0; DRAIN -> FETCH when discard reaches 0;
//   br_taken in any state with next discard == 0 -> FETCH. imem_rvalid ignored in IDLE.
//  Issue: imem_req = (state==FETCH) && (outstanding + fifo_count < FIFO_DEPTH). imem_addr = pc.
//   Once raised, req and addr are held stable until gnt, except via br_taken or rst.
//   On accept: pc <= pc + 4 (wraps at 2^XLEN), outstanding++.
//  Response: rvalid with discard==0 pushes {rdata, pc of that request} into FIFO, outstanding--;
//   rvalid with discard>0 is dropped, discard--, outstanding--. Credit rule guarantees no overflow.
//  Output: inst/inst_pc/inst_pc8 driven from FIFO head; inst_valid = !empty && !br_taken.
//   Pop, push and accept in the same cycle are all legal; FIFO count updates by push - pop.
//   Empty FIFO with rvalid: instruction visible on inst_valid the next cycle (no bypass).
//  Redirect (br_taken): FIFO flushed, no pop that cycle; pc <= {br_target[XLEN-1:2], 2'b00};
//   discard <= outstanding + (req && gnt) - (rvalid), i.e. a same-cycle accept is counted as stale
//   and a same-cycle response is dropped. The next request is to br_target. br_taken in DRAIN
//   recomputes discard by the same rule, and the last target wins.
//  Reset mid-operation: all state cleared at once; instruction memory is reset by the same rst,
//   so no response from before reset is delivered.
// STRUCTURE
//  fetch_pkg: XLEN default, fetch_state_t enum {IDLE, FETCH, DRAIN}, fetch_entry_t struct {inst, pc},
//   PC_STEP=4, PC_READ_OFS=8.
//  Sub-module fetch_fifo: sync FIFO of fetch_entry_t, FIFO_DEPTH entries, with push/pop/flush,
//   count, empty. Flush has priority over push and pop. Top-level has FSM, PC, outstanding/discard counters.
// TESTING
//  1 Reset, gnt=1, rvalid latency 1, dec_ready=1 -> addrs 0,4,8,... and inst_pc 0,4,8 in order, inst_pc8=8,12,16.
//  2 dec_ready=0 -> exactly FIFO_DEPTH(2) accepts, then imem_req=0. Raise ready -> one pop per cycle, req resumes.
//  3 gnt held 0 for 3 cycles -> imem_req=1 and imem_addr stable; pc does not advance.
//  4 Latency 3 with 2 outstanding, then br_taken target 0x103 -> DRAIN, 2 responses dropped,
//    next addr=0x100, first inst_pc=0x100.
//  5 Same cycle br_taken + accept + rvalid -> discard = outstanding; no stale inst reaches decode.
//  6 rst asserted mid-burst -> outputs return to reset values that same cycle. PC at 0xFFFFFFFC -> next addr 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  // Default datapath width; the fetch FIFO entry is built from this width.
  localparam int DEF_XLEN    = 32;
  localparam int PC_STEP     = 4;
  localparam int PC_READ_OFS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [DEF_XLEN-1:0] inst;
    logic [DEF_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {inst, pc} entries between imem responses and decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int                  DEPTH  = 2,
  parameter logic [DEF_XLEN-1:0] RST_PC = '0,
  parameter int                  CW     = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic [CW-1:0] count,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage and pointers; flush beats push/pop so a redirect always leaves the FIFO empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{inst: '0, pc: RST_PC};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: PC, imem req/gnt issue, in-order response buffering, redirect flush.
// XLEN must match fetch_pkg::DEF_XLEN since the buffer entry type is built from it.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN       = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            inst_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] inst_pc8
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc;       // next address to request
  logic [XLEN-1:0] rsp_pc;   // address belonging to the next non-stale response
  logic [CW-1:0]   outstanding, out_nxt;
  logic [CW-1:0]   discard, disc_nxt;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            accept, rv, push, pop;
  logic [XLEN-1:0] br_tgt;
  fetch_entry_t    fifo_din, fifo_dout;

  assign br_tgt = br_target & ~XLEN'(3);
  assign accept = imem_req && imem_gnt;
  assign rv     = imem_rvalid && (state != IDLE);
  // A response arriving with a redirect is stale, as is anything owed to the discard count.
  assign push   = rv && (discard == '0) && !br_taken;
  assign pop    = inst_valid && dec_ready;

  // Issue credit, counter updates and FSM next state.
  always_comb begin
    imem_req  = (state == FETCH) &&
                (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH));
    out_nxt   = outstanding + CW'(accept) - CW'(rv);
    disc_nxt  = discard;
    state_nxt = state;
    // Everything still in flight after this cycle belongs to the old path, so it is all stale.
    if (br_taken)                    disc_nxt = out_nxt;
    else if (rv && discard != '0)    disc_nxt = discard - CW'(1);
    case (state)
      IDLE:    state_nxt = FETCH;
      DRAIN:   if (disc_nxt == '0) state_nxt = FETCH;
      default: state_nxt = state;
    endcase
    if (br_taken) state_nxt = (disc_nxt != '0) ? DRAIN : FETCH;
  end

  // State, PC and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      discard     <= disc_nxt;
      if (br_taken)    pc <= br_tgt;
      else if (accept) pc <= pc + XLEN'(PC_STEP);
      if (br_taken)    rsp_pc <= br_tgt;
      else if (push)   rsp_pc <= rsp_pc + XLEN'(PC_STEP);
    end
  end

  assign fifo_din = '{inst: imem_rdata, pc: rsp_pc};

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .RST_PC (RESET_PC),
    .CW     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (br_taken),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign imem_addr  = pc;
  assign inst_valid = !fifo_empty && !br_taken;
  assign inst       = fifo_dout.inst;
  assign inst_pc    = fifo_dout.pc;
  assign inst_pc8   = fifo_dout.pc + XLEN'(PC_READ_OFS);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural in-order instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] K = 32'hE5A0_0000;  // imem returns addr ^ K

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_valid, dec_ready;
  logic [31:0] inst, inst_pc, inst_pc8;

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 1;
  int cyc    = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  logic [31:0] acc_q[$], dpc_q[$], dinst_q[$], dpc8_q[$];

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .inst_valid  (inst_valid),
    .dec_ready   (dec_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_pc8    (inst_pc8)
  );

  always #5 clk = ~clk;

  // Memory model: log accepts and pops, return responses in order after lat cycles.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      rq.delete();
    end else begin
      if (imem_req && imem_gnt) begin
        rq.push_back('{addr: imem_addr, due: cyc + lat});
        acc_q.push_back(imem_addr);
      end
      if (inst_valid && dec_ready) begin
        dpc_q.push_back(inst_pc);
        dinst_q.push_back(inst);
        dpc8_q.push_back(inst_pc8);
      end
    end
    #1;
    if (!rst && rq.size() > 0 && rq[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = rq[0].addr ^ K;
      void'(rq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    br_taken  = 1'b0;
    br_target = '0;
    @(negedge clk);
    @(negedge clk);
    acc_q.delete(); dpc_q.delete(); dinst_q.delete(); dpc8_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_gnt = 1'b0; dec_ready = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(imem_req),   32'd0);
    chk("rst_addr",  imem_addr,       32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst",  inst,            32'h0);
    chk("rst_pc",    inst_pc,         32'h0);
    chk("rst_pc8",   inst_pc8,        32'h8);

    // 1: streaming, latency 1
    imem_gnt = 1'b1; dec_ready = 1'b1; lat = 1;
    do_reset();
    repeat (10) @(negedge clk);
    chk("t1_acc0",  acc_q[0],   32'h0);
    chk("t1_acc1",  acc_q[1],   32'h4);
    chk("t1_acc2",  acc_q[2],   32'h8);
    chk("t1_pc0",   dpc_q[0],   32'h0);
    chk("t1_pc1",   dpc_q[1],   32'h4);
    chk("t1_pc2",   dpc_q[2],   32'h8);
    chk("t1_pc8_0", dpc8_q[0],  32'h8);
    chk("t1_pc8_1", dpc8_q[1],  32'hC);
    chk("t1_pc8_2", dpc8_q[2],  32'h10);
    chk("t1_inst0", dinst_q[0], 32'hE5A0_0000);
    chk("t1_inst2", dinst_q[2], 32'hE5A0_0008);

    // 2: decode stalled -> credit cap, then one pop per cycle
    dec_ready = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    chk("t2_nacc",  acc_q.size(),     32'd2);
    chk("t2_req0",  32'(imem_req),    32'd0);
    chk("t2_valid", 32'(inst_valid),  32'd1);
    chk("t2_head",  inst_pc,          32'h0);
    dec_ready = 1'b1;
    @(negedge clk);
    chk("t2_head1", inst_pc,          32'h4);
    chk("t2_req1",  32'(imem_req),    32'd1);
    chk("t2_npop",  dpc_q.size(),     32'd1);
    repeat (6) @(negedge clk);
    chk("t2_pc1",   dpc_q[1],         32'h4);
    chk("t2_pc2",   dpc_q[2],         32'h8);
    // full FIFO hidden from decode during a redirect, then flushed
    dec_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("t2_full_v", 32'(inst_valid), 32'd1);
    br_taken = 1'b1; br_target = 32'h43;
    #1;
    chk("t2_br_v",   32'(inst_valid), 32'd0);
    @(negedge clk);
    br_taken = 1'b0;
    chk("t2_flush_v", 32'(inst_valid), 32'd0);
    chk("t2_br_req",  32'(imem_req),   32'd1);
    chk("t2_br_addr", imem_addr,       32'h40);

    // 3: grant withheld 3 cycles
    imem_gnt = 1'b0; dec_ready = 1'b1; lat = 1;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("t3_req_hold",  32'(imem_req), 32'd1);
      chk("t3_addr_hold", imem_addr,     32'h0);
      @(negedge clk);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("t3_addr_next", imem_addr,    32'h4);
    chk("t3_nacc",      acc_q.size(), 32'd1);

    // 4: latency 3, two stale in flight, redirect to 0x103
    lat = 3;
    do_reset();
    repeat (3) @(negedge clk);
    chk("t4_cap_req", 32'(imem_req), 32'd0);
    chk("t4_nacc",    acc_q.size(),  32'd2);
    br_taken = 1'b1; br_target = 32'h103;
    @(negedge clk);
    br_taken = 1'b0;
    chk("t4_drain_req0", 32'(imem_req),   32'd0);
    @(negedge clk);
    chk("t4_drain_req1", 32'(imem_req),   32'd0);
    chk("t4_drain_v",    32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("t4_req",  32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr,     32'h100);
    repeat (10) @(negedge clk);
    chk("t4_npop",  32'(dpc_q.size() > 0), 32'd1);
    chk("t4_pc0",   dpc_q[0],   32'h100);
    chk("t4_inst0", dinst_q[0], 32'hE5A0_0100);

    // 5: redirect coincides with accept and response
    lat = 1;
    do_reset();
    repeat (2) @(negedge clk);
    chk("t5_pre_req",  32'(imem_req), 32'd1);
    chk("t5_pre_addr", imem_addr,     32'h4);
    br_taken = 1'b1; br_target = 32'h200;
    @(negedge clk);
    br_taken = 1'b0;
    chk("t5_drain_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("t5_req",  32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr,     32'h200);
    repeat (8) @(negedge clk);
    chk("t5_npop", 32'(dpc_q.size() >= 2), 32'd1);
    chk("t5_pc0",  dpc_q[0], 32'h200);
    chk("t5_pc1",  dpc_q[1], 32'h204);

    // 6a: reset mid-burst, outputs clear without waiting for a clock
    lat = 2;
    do_reset();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_req",   32'(imem_req),   32'd0);
    chk("t6_addr",  imem_addr,       32'h0);
    chk("t6_valid", 32'(inst_valid), 32'd0);
    chk("t6_inst",  inst,            32'h0);
    chk("t6_pc",    inst_pc,         32'h0);
    chk("t6_pc8",   inst_pc8,        32'h8);

    // 6b: PC wrap at the top of the address space
    imem_gnt = 1'b0; lat = 1;
    do_reset();
    @(negedge clk);
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    @(negedge clk);
    br_taken = 1'b0;
    chk("t6_top_req",  32'(imem_req), 32'd1);
    chk("t6_top_addr", imem_addr,     32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    @(negedge clk);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    repeat (6) @(negedge clk);
    chk("t6_wrap_pc0",   dpc_q[0],   32'hFFFF_FFFC);
    chk("t6_wrap_pc8",   dpc8_q[0],  32'h4);
    chk("t6_wrap_inst0", dinst_q[0], 32'h1A5F_FFFC);
    chk("t6_wrap_pc1",   dpc_q[1],   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
